alu_exec_ctrl: RTL

//  Issue side of topALU: accepts one ALU operation per request, drives aluControl/a/b,

---
 rtl/alu_exec_pkg.sv | 32 +++
 rtl/cond_check.sv | 39 +++
 rtl/alu_exec_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU issue/execute controller.
package alu_exec_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned COND_W = 4;
  localparam int unsigned NFLAGS = 4;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [COND_W-1:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator: (cond, {N,Z,C,V}) -> pass.
module cond_check
  import alu_exec_pkg::*;
(
  input  logic [COND_W-1:0] cond_i,
  input  logic [NFLAGS-1:0] flags_i,
  output logic              pass_c
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_c = 1'b0;
    case (cond_t'(cond_i))
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = !c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = !n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = !v;
      COND_HI: pass_c = c && !z;
      COND_LS: pass_c = !c || z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = !z && (n == v);
      COND_LE: pass_c = z || (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/execute controller around topALU: latches a request, runs it for one cycle,
// holds the result until consumed. ALU_COND_EXEC_EN enables ARM conditional execution.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [COND_W-1:0] in_cond,
  input  logic              in_setflags,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic [OP_W-1:0]   alu_control,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [NFLAGS-1:0] alu_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_executed,
  output logic [NFLAGS-1:0] flags_q
);

  state_t state_q;
  logic   setflags_q;
  logic   accept_c;
  logic   pass_c;

  // A slot frees up in DONE in the same cycle the consumer takes the result
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_c = in_valid && in_ready;

`ifdef ALU_COND_EXEC_EN
  logic [COND_W-1:0] cond_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q <= '0;
    end else if (accept_c) begin
      cond_q <= in_cond;
    end
  end

  cond_check u_cond_check (
    .cond_i  (cond_q),
    .flags_i (flags_q),
    .pass_c  (pass_c)
  );
`else
  logic unused_cond;
  assign unused_cond = ^in_cond;
  assign pass_c      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      setflags_q   <= 1'b0;
      alu_control  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_executed <= 1'b0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            alu_control <= in_op;
            alu_a       <= in_a;
            alu_b       <= in_b;
            setflags_q  <= in_setflags;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result   <= pass_c ? alu_result : '0;
          out_executed <= pass_c;
          if (pass_c && setflags_q) begin
            flags_q <= alu_flags;
          end
          out_valid   <= 1'b1;
          alu_control <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept_c) begin
              alu_control <= in_op;
              alu_a       <= in_a;
              alu_b       <= in_b;
              setflags_q  <= in_setflags;
              state_q     <= ST_EXEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
